// File: rtl/kamacore_dmem_responder.sv
// kamacore_dmem_responder
//   Data-memory responder for the memory stage. It accepts one load or store
//   over a valid/ready request channel and waits WAIT_CYCLES extra cycles.
//   It then performs the access on a word-organised array and returns the
//   result over a valid/ready response channel.
//   Sub-word stores are byte-lane steered. Sub-word loads are sign- or
//   zero-extended. Misaligned, reserved-size and out-of-range accesses are
//   rejected with rsp_err_o.
//
// Ports
//   clk_i           clock
//   rst_i           synchronous active-high reset
//   req_valid_i     request present
//   req_ready_o     responder can accept a request (IDLE and not in reset)
//   req_we_i        1 = store, 0 = load
//   req_addr_i      byte address
//   req_wdata_i     store data, right-justified for sub-word stores
//   req_size_i      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned_i  zero-extend sub-word loads when 1
//   rsp_valid_o     response present
//   rsp_ready_i     requester accepts the response
//   rsp_rdata_o     load result; 0 for stores and errors
//   rsp_err_o       access rejected
module kamacore_dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int          IW         = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CW         = $clog2(WAIT_CYCLES + 2);
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q;
  logic [CW-1:0] waitCnt_q;
  logic          latWe_q;
  logic [31:0]   latAddr_q;
  logic [31:0]   latWdata_q;
  logic [1:0]    latSize_q;
  logic          latUns_q;
  logic          rspValid_q;
  logic [31:0]   rspRdata_q;
  logic          rspErr_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic          accWe;
  logic [31:0]   accAddr;
  logic [31:0]   accWdata;
  logic [1:0]    accSize;
  logic          accUns;
  logic          accErr;
  logic          doAccess;
  logic          memWe;
  logic [IW-1:0] wordIdx;
  logic [31:0]   rdWord;
  logic [31:0]   shifted;
  logic [31:0]   loadData;
  logic [3:0]    byteEn;
  logic [31:0]   wrData;
  logic [31:0]   rspRdata_d;

  assign req_ready_o = (state_q == S_IDLE) && !rst_i;
  assign rsp_valid_o = rspValid_q;
  assign rsp_rdata_o = rspRdata_q;
  assign rsp_err_o   = rspErr_q;

  // The access uses the live request fields when it happens on the
  // acceptance edge (WAIT_CYCLES == 0). Otherwise it uses the latched copy.
  always_comb begin
    if (state_q == S_IDLE) begin
      accWe    = req_we_i;
      accAddr  = req_addr_i;
      accWdata = req_wdata_i;
      accSize  = req_size_i;
      accUns   = req_unsigned_i;
    end else begin
      accWe    = latWe_q;
      accAddr  = latAddr_q;
      accWdata = latWdata_q;
      accSize  = latSize_q;
      accUns   = latUns_q;
    end
  end

  // Reject the access on reserved size, misalignment or an address past the array.
  always_comb begin
    accErr = 1'b0;
    if (accSize == 2'b11)                           accErr = 1'b1;
    if (accSize == 2'b01 && accAddr[0])             accErr = 1'b1;
    if (accSize == 2'b10 && accAddr[1:0] != 2'b00)  accErr = 1'b1;
    if ({1'b0, accAddr} >= BYTE_LIMIT)              accErr = 1'b1;
  end

  assign doAccess = ((state_q == S_IDLE) && req_valid_i && (WAIT_CYCLES == 0)) ||
                    ((state_q == S_WAIT) && (waitCnt_q == '0));
  assign memWe    = doAccess && accWe && !accErr && !rst_i;
  assign wordIdx  = accAddr[IW+1:2];
  assign rdWord   = mem[wordIdx];

  // Alignment is already checked, so shifting by lane*8 lands both byte and
  // half-word lanes at bit 0.
  always_comb begin
    shifted = rdWord >> {accAddr[1:0], 3'b000};
    case (accSize)
      2'b00:   loadData = {{24{~accUns & shifted[7]}}, shifted[7:0]};
      2'b01:   loadData = {{16{~accUns & shifted[15]}}, shifted[15:0]};
      default: loadData = rdWord;
    endcase
    rspRdata_d = (accWe || accErr) ? 32'h0 : loadData;
  end

  // Store data is replicated across lanes. The byte enables select which
  // lanes actually change.
  always_comb begin
    case (accSize)
      2'b00: begin
        byteEn = 4'b0001 << accAddr[1:0];
        wrData = {4{accWdata[7:0]}};
      end
      2'b01: begin
        byteEn = 4'b0011 << accAddr[1:0];
        wrData = {2{accWdata[15:0]}};
      end
      default: begin
        byteEn = 4'b1111;
        wrData = accWdata;
      end
    endcase
  end

  // The array has no reset; it is written only on a clean store commit.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (memWe && byteEn[b]) mem[wordIdx][b*8 +: 8] <= wrData[b*8 +: 8];
    end
  end

  // Control FSM with registered response outputs. Reset drops any
  // in-flight access or pending response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      waitCnt_q  <= '0;
      rspValid_q <= 1'b0;
      rspRdata_q <= 32'h0;
      rspErr_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            latWe_q    <= req_we_i;
            latAddr_q  <= req_addr_i;
            latWdata_q <= req_wdata_i;
            latSize_q  <= req_size_i;
            latUns_q   <= req_unsigned_i;
            if (WAIT_CYCLES == 0) begin
              state_q    <= S_RESP;
              rspValid_q <= 1'b1;
              rspRdata_q <= rspRdata_d;
              rspErr_q   <= accErr;
            end else begin
              state_q   <= S_WAIT;
              waitCnt_q <= CW'(WAIT_CYCLES - 1);
            end
          end
        end
        S_WAIT: begin
          if (waitCnt_q == '0) begin
            state_q    <= S_RESP;
            rspValid_q <= 1'b1;
            rspRdata_q <= rspRdata_d;
            rspErr_q   <= accErr;
          end else begin
            waitCnt_q <= waitCnt_q - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            state_q    <= S_IDLE;
            rspValid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kamacore_dmem_responder.sv
// tb_kamacore_dmem_responder
//   Directed, table-driven bench for kamacore_dmem_responder. Each table
//   record is a full request plus its expected response. Hand-written
//   sequences cover back-pressure on the response channel and reset during
//   WAIT and RESP.
module tb_kamacore_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WC    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWe = 1'b0;
  logic [31:0] reqAddr = '0;
  logic [31:0] reqWdata = '0;
  logic [1:0]  reqSize = '0;
  logic        reqUns = 1'b0;
  logic        rspValid;
  logic        rspReady = 1'b0;
  logic [31:0] rspRdata;
  logic        rspErr;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] expRdata;
    logic        expErr;
  } vec_t;

  vec_t vecs[$];

  kamacore_dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WC)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_we_i(reqWe),
    .req_addr_i(reqAddr), .req_wdata_i(reqWdata), .req_size_i(reqSize),
    .req_unsigned_i(reqUns),
    .rsp_valid_o(rspValid), .rsp_ready_i(rspReady),
    .rsp_rdata_o(rspRdata), .rsp_err_o(rspErr)
  );

  always #5 clk = ~clk;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        input logic [31:0] expRdata, input logic expErr);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
    v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // Present a request and wait (bounded) until it is accepted.
  task automatic sendReq(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns);
    int n;
    reqWe = we; reqAddr = addr; reqWdata = wdata; reqSize = size; reqUns = uns;
    reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 20) begin tick(); n++; end
    if (!reqReady) checkOutput({name, " req_ready timeout"}, 32'(reqReady), 32'd1);
    tick();
    reqValid = 1'b0;
  endtask

  // Wait (bounded) for rsp_valid; returns the number of edges after acceptance.
  task automatic waitRsp(output int lat);
    lat = 0;
    while (!rspValid && lat < 30) begin tick(); lat++; end
  endtask

  // Run one full transaction and check latency, rdata and err.
  task automatic applyStimulus(input string name, input vec_t v);
    int lat;
    sendReq(name, v.we, v.addr, v.wdata, v.size, v.uns);
    waitRsp(lat);
    checkOutput({name, " latency"}, 32'(lat), 32'(WC));
    checkOutput({name, " rdata"}, rspRdata, v.expRdata);
    checkOutput({name, " err"}, 32'(rspErr), 32'(v.expErr));
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] holdRdata;
    logic        holdErr;
    int          lat;

    // Directed table: {we, addr, wdata, size, uns, expRdata, expErr}
    addVec(1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0,        0);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
    addVec(1, 32'h10,   32'h11223344, 2'b10, 0, 32'h0,        0);
    addVec(1, 32'h13,   32'hAAAAAA80, 2'b00, 0, 32'h0,        0);
    addVec(0, 32'h13,   32'h0,        2'b00, 0, 32'hFFFFFF80, 0);
    addVec(0, 32'h13,   32'h0,        2'b00, 1, 32'h00000080, 0);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'h80223344, 0);
    addVec(1, 32'h10,   32'h80017FFF, 2'b10, 0, 32'h0,        0);
    addVec(0, 32'h12,   32'h0,        2'b01, 0, 32'hFFFF8001, 0);
    addVec(0, 32'h12,   32'h0,        2'b01, 1, 32'h00008001, 0);
    addVec(0, 32'h10,   32'h0,        2'b01, 0, 32'h00007FFF, 0);
    addVec(0, 32'h11,   32'h0,        2'b01, 0, 32'h0,        1);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'h80017FFF, 0);
    addVec(1, 32'h12,   32'h1234ABCD, 2'b01, 0, 32'h0,        0);
    addVec(0, 32'h10,   32'h0,        2'b10, 1, 32'hABCD7FFF, 0);
    addVec(0, 32'h11,   32'h0,        2'b00, 0, 32'h0000007F, 0);
    addVec(0, 32'h10,   32'h0,        2'b00, 1, 32'h000000FF, 0);
    addVec(0, 32'h10,   32'h0,        2'b00, 0, 32'hFFFFFFFF, 0);
    addVec(0, 32'h1000, 32'h0,        2'b10, 0, 32'h0,        1);
    addVec(1, 32'hFFC,  32'h5555AAAA, 2'b10, 0, 32'h0,        0);
    addVec(0, 32'hFFC,  32'h0,        2'b10, 0, 32'h5555AAAA, 0);
    addVec(0, 32'hFFF,  32'h0,        2'b00, 0, 32'h00000055, 0);
    addVec(0, 32'h10,   32'h0,        2'b11, 0, 32'h0,        1);
    addVec(1, 32'h12,   32'hFFFFFFFF, 2'b10, 0, 32'h0,        1);
    addVec(1, 32'h13,   32'hFFFFFFFF, 2'b01, 0, 32'h0,        1);
    addVec(1, 32'h1000, 32'hFFFFFFFF, 2'b10, 0, 32'h0,        1);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'hABCD7FFF, 0);
    addVec(1, 32'h20,   32'h01020304, 2'b10, 0, 32'h0,        0);
    addVec(0, 32'h20,   32'h0,        2'b10, 0, 32'h01020304, 0);

    // Reset held for two edges, then released.
    rst = 1'b1;
    tick();
    checkOutput("reset req_ready during rst", 32'(reqReady), 32'd0);
    tick();
    checkOutput("reset req_ready during rst 2", 32'(reqReady), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset req_ready after", 32'(reqReady), 32'd1);
    checkOutput("reset rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset rsp_rdata", rspRdata, 32'd0);
    checkOutput("reset rsp_err", 32'(rspErr), 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // Back-pressure: the response holds and new requests are ignored.
    sendReq("hold", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0);
    waitRsp(lat);
    checkOutput("hold latency", 32'(lat), 32'(WC));
    holdRdata = rspRdata;
    holdErr   = rspErr;
    checkOutput("hold first rdata", holdRdata, 32'hABCD7FFF);
    reqWe = 1'b1; reqAddr = 32'h10; reqWdata = 32'h0; reqSize = 2'b10; reqValid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      checkOutput($sformatf("hold c%0d rsp_valid", c), 32'(rspValid), 32'd1);
      checkOutput($sformatf("hold c%0d rdata", c), rspRdata, holdRdata);
      checkOutput($sformatf("hold c%0d err", c), 32'(rspErr), 32'(holdErr));
      checkOutput($sformatf("hold c%0d req_ready", c), 32'(reqReady), 32'd0);
    end
    reqValid = 1'b0;
    rspReady = 1'b1;
    tick();
    rspReady = 1'b0;
    checkOutput("hold after handshake rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("hold after handshake req_ready", 32'(reqReady), 32'd1);
    applyStimulus("hold ignored store", '{1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hABCD7FFF, 1'b0});

    // Reset during WAIT drops the pending store to 0x20.
    sendReq("rstwait", 1'b1, 32'h20, 32'hFFFFFFFF, 2'b10, 1'b0);
    rst = 1'b1;
    tick();
    checkOutput("rstwait rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rstwait req_ready in rst", 32'(reqReady), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rstwait req_ready after", 32'(reqReady), 32'd1);
    for (int c = 0; c < 3; c++) tick();
    checkOutput("rstwait no late rsp", 32'(rspValid), 32'd0);
    applyStimulus("rstwait old value", '{1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h01020304, 1'b0});

    // Reset during RESP discards the response.
    sendReq("rstresp", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0);
    waitRsp(lat);
    checkOutput("rstresp rsp_valid before", 32'(rspValid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checkOutput("rstresp rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("rstresp rdata", rspRdata, 32'd0);
    checkOutput("rstresp err", 32'(rspErr), 32'd0);
    checkOutput("rstresp req_ready", 32'(reqReady), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
